// File: rtl/am_ctrl.sv
// am_ctrl: AM modulation-depth controller (static depth, optional triangle/single sweep).
// Define AM_CTRL_SWEEP_EN to compile in the UP/DOWN/HOLD sweep states and the dwell register.
module am_ctrl #(
  parameter int DIV_W  = 16,
  parameter int MA_MIN = 1,
  parameter int MA_MAX = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  ma,
  output logic        sample_tick,
  output logic [2:0]  state,
  output logic        sweep_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STATIC = 3'd1;
  localparam logic [2:0] S_UP     = 3'd2;
  localparam logic [2:0] S_DOWN   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [3:0] MA_LO = 4'(MA_MIN);
  localparam logic [3:0] MA_HI = 4'(MA_MAX);

  logic [1:0]       mode_sh;
  logic [1:0]       mode_act;
  logic [3:0]       ma_static_sh;
  logic [3:0]       ma_static_act;
  logic [DIV_W-1:0] tick_div_sh;
  logic [DIV_W-1:0] tick_div_act;
  logic [DIV_W-1:0] div_cnt;

  logic       running;
  logic       apply;
  logic       mode_changed;
  logic [3:0] ma_static_eff;
  logic [2:0] entry_state;

`ifdef AM_CTRL_SWEEP_EN
  localparam logic [4:0] MA_TOP    = 5'(MA_MAX);
  localparam logic [4:0] MA_BOT_P1 = 5'(MA_MIN + 1);

  logic [7:0] dwell_sh;
  logic [7:0] dwell_act;
  logic [7:0] dwell_eff;
  logic [7:0] dwell_cnt;
  logic [1:0] mode_eff;
  logic       done_q;
`endif

  function automatic logic [3:0] clamp_ma(input logic [3:0] v);
    if (v < MA_LO)
      return MA_LO;
    else if (v > MA_HI)
      return MA_HI;
    else
      return v;
  endfunction

  assign running     = (state != S_IDLE);
  assign sample_tick = running && (div_cnt == tick_div_act);

  // Shadows become active on a tick or while idle; the "eff" values are what
  // this edge will use, so a freshly applied setting takes effect at its tick.
  assign apply         = sample_tick || !running;
  assign ma_static_eff = apply ? ma_static_sh : ma_static_act;
  assign mode_changed  = sample_tick && (mode_sh != mode_act);

`ifdef AM_CTRL_SWEEP_EN
  assign mode_eff    = apply ? mode_sh : mode_act;
  assign dwell_eff   = apply ? dwell_sh : dwell_act;
  assign entry_state = (mode_eff == 2'd1 || mode_eff == 2'd2) ? S_UP : S_STATIC;
  assign sweep_done  = done_q;
`else
  assign entry_state = S_STATIC;
  assign sweep_done  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sh      <= 2'd0;
      ma_static_sh <= MA_LO;
      tick_div_sh  <= '0;
`ifdef AM_CTRL_SWEEP_EN
      dwell_sh     <= 8'd0;
`endif
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    mode_sh      <= cfg_wdata[1:0];
        2'd1:    ma_static_sh <= cfg_wdata[3:0];
        2'd2:    tick_div_sh  <= DIV_W'(cfg_wdata);
`ifdef AM_CTRL_SWEEP_EN
        2'd3:    dwell_sh     <= cfg_wdata[7:0];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_act      <= 2'd0;
      ma_static_act <= MA_LO;
      tick_div_act  <= '0;
`ifdef AM_CTRL_SWEEP_EN
      dwell_act     <= 8'd0;
`endif
    end else if (apply) begin
      mode_act      <= mode_sh;
      ma_static_act <= ma_static_sh;
      tick_div_act  <= tick_div_sh;
`ifdef AM_CTRL_SWEEP_EN
      dwell_act     <= dwell_sh;
`endif
    end
  end

  // Divider restarts from zero on every (re)entry and on leaving for IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (!running || stop || start || sample_tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ma        <= MA_LO;
`ifdef AM_CTRL_SWEEP_EN
      dwell_cnt <= 8'd0;
      done_q    <= 1'b0;
`endif
    end else begin
`ifdef AM_CTRL_SWEEP_EN
      done_q <= 1'b0;
`endif
      if (stop) begin
        state <= S_IDLE;
        ma    <= MA_LO;
      end else if (start || mode_changed) begin
        state     <= entry_state;
        ma        <= MA_LO;
`ifdef AM_CTRL_SWEEP_EN
        dwell_cnt <= 8'd0;
`endif
      end else begin
        case (state)
          S_IDLE: ma <= MA_LO;
          S_STATIC: begin
            if (sample_tick)
              ma <= clamp_ma(ma_static_eff);
          end
`ifdef AM_CTRL_SWEEP_EN
          S_UP: begin
            if (sample_tick) begin
              if (dwell_cnt >= dwell_eff) begin
                dwell_cnt <= 8'd0;
                if (({1'b0, ma} + 5'd1) >= MA_TOP) begin
                  ma <= MA_HI;
                  if (mode_eff == 2'd2) begin
                    state  <= S_HOLD;
                    done_q <= 1'b1;
                  end else begin
                    state <= S_DOWN;
                  end
                end else begin
                  ma <= ma + 4'd1;
                end
              end else begin
                dwell_cnt <= dwell_cnt + 8'd1;
              end
            end
          end
          S_DOWN: begin
            if (sample_tick) begin
              if (dwell_cnt >= dwell_eff) begin
                dwell_cnt <= 8'd0;
                if ({1'b0, ma} <= MA_BOT_P1) begin
                  ma    <= MA_LO;
                  state <= S_UP;
                end else begin
                  ma <= ma - 4'd1;
                end
              end else begin
                dwell_cnt <= dwell_cnt + 8'd1;
              end
            end
          end
          S_HOLD: begin
            if (sample_tick)
              ma <= MA_HI;
          end
`else
          S_UP, S_DOWN, S_HOLD: begin
            state <= S_IDLE;
            ma    <= MA_LO;
          end
`endif
          default: begin
            state <= S_IDLE;
            ma    <= MA_LO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_am_ctrl.sv
// tb_am_ctrl: randomized self-checking bench for am_ctrl against a tick-scheduled behavioural model.
// Follows AM_CTRL_SWEEP_EN so the model matches whichever build is compiled.
module tb_am_ctrl;

  localparam int DIV_W  = 16;
  localparam int MA_MIN = 1;
  localparam int MA_MAX = 10;
`ifdef AM_CTRL_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  ma;
  logic        sample_tick;
  logic [2:0]  state;
  logic        sweep_done;

  int checks = 0;
  int errors = 0;

  // Model: configuration seen by the user plus the schedule of the next tick
  int sh_mode, sh_mast, sh_td, sh_dw;
  int act_mode, act_mast, act_td, act_dw;
  bit m_running, m_sweep, m_rising, m_hold, m_done;
  int m_ma, m_held, next_tick, cyc;

  am_ctrl #(.DIV_W(DIV_W), .MA_MIN(MA_MIN), .MA_MAX(MA_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .stop(stop), .ma(ma), .sample_tick(sample_tick), .state(state),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  function automatic int clampMa(input int v);
    return (v < MA_MIN) ? MA_MIN : (v > MA_MAX) ? MA_MAX : v;
  endfunction

  function automatic int expState();
    if (!m_running) return 0;
    if (!m_sweep) return 1;
    if (m_hold) return 4;
    return m_rising ? 2 : 3;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    sh_mode = 0; sh_mast = MA_MIN; sh_td = 0; sh_dw = 0;
    act_mode = 0; act_mast = MA_MIN; act_td = 0; act_dw = 0;
    m_running = 0; m_sweep = 0; m_rising = 1; m_hold = 0; m_done = 0;
    m_ma = MA_MIN; m_held = 0; next_tick = 0;
  endtask

  task automatic enterRun(input int mode, input int td);
    m_running = 1;
    m_sweep   = SWEEP && (mode == 1 || mode == 2);
    m_rising  = 1;
    m_hold    = 0;
    m_held    = 0;
    m_ma      = MA_MIN;
    next_tick = cyc + 1 + td;
  endtask

  task automatic modelStep(input bit we, input int addr, input int wdata, input bit st, input bit sp);
    bit tick, apply;
    int n_mode, n_mast, n_td, n_dw;
    tick   = m_running && (cyc == next_tick);
    apply  = tick || !m_running;
    n_mode = apply ? sh_mode : act_mode;
    n_mast = apply ? sh_mast : act_mast;
    n_td   = apply ? sh_td : act_td;
    n_dw   = apply ? sh_dw : act_dw;
    if (we) begin
      case (addr)
        0: sh_mode = wdata & 3;
        1: sh_mast = wdata & 15;
        2: sh_td = wdata & 16'hffff;
        default: if (SWEEP) sh_dw = wdata & 255;
      endcase
    end
    m_done = 0;
    if (sp) begin
      m_running = 0;
      m_ma = MA_MIN;
    end else if (st) begin
      enterRun(n_mode, n_td);
    end else if (tick) begin
      if (n_mode != act_mode) begin
        enterRun(n_mode, n_td);
      end else begin
        next_tick = cyc + 1 + n_td;
        if (!m_sweep) begin
          m_ma = clampMa(n_mast);
        end else if (m_hold) begin
          m_ma = MA_MAX;
        end else begin
          m_held++;
          if (m_held >= n_dw + 1) begin
            m_held = 0;
            if (m_rising) begin
              m_ma++;
              if (m_ma == MA_MAX) begin
                if (n_mode == 2) begin
                  m_hold = 1;
                  m_done = 1;
                end else begin
                  m_rising = 0;
                end
              end
            end else begin
              m_ma--;
              if (m_ma == MA_MIN) m_rising = 1;
            end
          end
        end
      end
    end
    act_mode = n_mode; act_mast = n_mast; act_td = n_td; act_dw = n_dw;
    cyc++;
  endtask

  // Called at a falling edge: check this cycle's outputs, then drive the next inputs
  task automatic applyStimulus(input bit we, input int addr, input int wdata, input bit st, input bit sp);
    checkOutput("state", int'(state), expState());
    checkOutput("ma", int'(ma), m_ma);
    checkOutput("sample_tick", int'(sample_tick), (m_running && cyc == next_tick) ? 1 : 0);
    checkOutput("sweep_done", int'(sweep_done), int'(m_done));
    cfg_we    = we;
    cfg_addr  = 2'(addr);
    cfg_wdata = 16'(wdata);
    start     = st;
    stop      = sp;
    modelStep(we, addr, wdata, st, sp);
    @(negedge clk);
  endtask

  task automatic writeReg(input int addr, input int data);
    applyStimulus(1'b1, addr, data, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    rst_n  = 1'b0;
    cfg_we = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    #1;
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_ma", int'(ma), MA_MIN);
    checkOutput("rst_tick", int'(sample_tick), 0);
    checkOutput("rst_done", int'(sweep_done), 0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit we, st, sp;
    int addr, data;
    cyc = 0;
    modelReset();
    @(negedge clk);
    resetDut();

    // tick_div=3 static run
    writeReg(2, 3);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    idle(12);

    // ma_static below and above the legal range
    writeReg(1, 0);
    idle(6);
    writeReg(1, 15);
    idle(6);

    // triangle sweep with dwell=1 at full tick rate
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    writeReg(0, 1);
    writeReg(2, 0);
    writeReg(3, 1);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    idle(45);

    // start and stop together while sweeping up
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    idle(3);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
    idle(3);

    // single sweep then hold
    writeReg(0, 2);
    writeReg(3, 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    idle(14);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

    // reset in the middle of a single sweep
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    idle(6);
    resetDut();
    idle(12);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        resetDut();
      end else begin
        we   = ($urandom_range(0, 5) == 0);
        addr = int'($urandom_range(0, 3));
        case (addr)
          0: data = int'($urandom_range(0, 3));
          1: data = int'($urandom_range(0, 15));
          2: data = int'($urandom_range(0, 4));
          default: data = int'($urandom_range(0, 3));
        endcase
        st = ($urandom_range(0, 30) == 0);
        sp = ($urandom_range(0, 50) == 0);
        applyStimulus(we, addr, data, st, sp);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
